// File: rtl/music_tone_gen_pkg.sv
// Note table and decode helpers shared by the tone generator and its divider.
package music_pkg;

  localparam int NOTE_W = 5;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam int NOTE_CNT = 21;

  localparam int FREQ_TAB [NOTE_CNT] = '{
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1046, 1175, 1318, 1397, 1568, 1760, 1976
  };

  typedef struct packed {
    logic [2:0] degree;
    logic [1:0] octave;
  } note_dec_t;

  function automatic logic is_tone(logic [NOTE_W-1:0] note);
    return (note != NOTE_REST) && (int'(note) <= NOTE_CNT);
  endfunction

  function automatic logic [15:0] half_period(logic [NOTE_W-1:0] note, int clk_hz);
    if (!is_tone(note)) return 16'd0;
    return 16'(clk_hz / (2 * FREQ_TAB[int'(note) - 1]));
  endfunction

  function automatic note_dec_t decode_note(logic [NOTE_W-1:0] note);
    note_dec_t d;
    d = '0;
    if (is_tone(note)) begin
      if (note <= 5'd7) begin
        d.degree = 3'(note);
        d.octave = 2'd1;
      end else if (note <= 5'd14) begin
        d.degree = 3'(note - 5'd7);
        d.octave = 2'd2;
      end else begin
        d.degree = 3'(note - 5'd14);
        d.octave = 2'd3;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/music_tone_gen_if.sv
// Note-in / speaker-and-display-out bundle between ROM reader and output stages.
interface music_tone_if;
  import music_pkg::*;

  logic [NOTE_W-1:0] note_in;
  logic              beat;
  logic              spk;
  logic [2:0]        degree;
  logic [1:0]        octave;
  logic              playing;

  modport master (output note_in, beat, input spk, degree, octave, playing);
  modport slave  (input note_in, beat, output spk, degree, octave, playing);
endinterface

// File: rtl/music_tone_gen_tone_div.sv
// Half-period counter with toggle flop; clear restarts the waveform low.
module tone_div (
  input  logic        inclock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] half,
  output logic        tone
);

  logic [15:0] cnt_q, cnt_d;
  logic        tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clear) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (enable) begin
      if (cnt_q == half - 16'd1) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge inclock) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/music_tone_gen.sv
// Note register, change detect, decode and square-wave drive for the speaker.
// Optional articulation gap after each beat when MUSIC_NOTE_GAP_EN is defined.
module music_tone_gen
  import music_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int GAP_TICKS = 120000
) (
  input  logic        inclock,
  input  logic        reset,
  music_tone_if.slave io
);

  logic [NOTE_W-1:0] note_q;
  logic [2:0]        degree_q;
  logic [1:0]        octave_q;
  logic              playing_q;
  logic              change;
  logic              tone;
  note_dec_t         dec_in;
  logic [15:0]       half_tab [32];

  // Halves are elaboration-time constants, so no divider is built.
  for (genvar g = 0; g < 32; g++) begin : g_half
    assign half_tab[g] = half_period(5'(g), CLK_HZ);
  end

  assign change = (io.note_in != note_q);
  assign dec_in = decode_note(io.note_in);

  always_ff @(posedge inclock) begin
    if (reset) begin
      note_q    <= NOTE_REST;
      degree_q  <= '0;
      octave_q  <= '0;
      playing_q <= 1'b0;
    end else if (change) begin
      note_q    <= io.note_in;
      degree_q  <= dec_in.degree;
      octave_q  <= dec_in.octave;
      playing_q <= is_tone(io.note_in);
    end
  end

  tone_div u_div (
    .inclock (inclock),
    .reset   (reset),
    .clear   (change),
    .enable  (is_tone(note_q)),
    .half    (half_tab[note_q]),
    .tone    (tone)
  );

`ifdef MUSIC_NOTE_GAP_EN
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  logic [GAP_W-1:0] gap_cnt_q;

  always_ff @(posedge inclock) begin
    if (reset)                gap_cnt_q <= '0;
    else if (io.beat)         gap_cnt_q <= GAP_W'(GAP_TICKS);
    else if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
  end

  assign io.spk = tone & (gap_cnt_q == '0);
`else
  logic beat_unused;
  assign beat_unused = io.beat;
  assign io.spk      = tone;
`endif

  assign io.degree  = degree_q;
  assign io.octave  = octave_q;
  assign io.playing = playing_q;

endmodule

// File: tb/tb_music_tone_gen.sv
// Bench for music_tone_gen: frequency/phase model plus pinned literal checks.
module tb_music_tone_gen;

  localparam int CLK   = 12000000;
  localparam int GAP   = 100;

  logic inclock = 1'b0;
  logic reset;
  music_tone_if bus ();

  music_tone_gen #(.CLK_HZ(CLK), .GAP_TICKS(GAP)) dut (
    .inclock (inclock),
    .reset   (reset),
    .io      (bus)
  );

  always #5 inclock = ~inclock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since the note was latched, and the tone frequency.
  int freq_hz [21] = '{262, 294, 330, 349, 392, 440, 494,
                       523, 587, 659, 698, 784, 880, 988,
                       1046, 1175, 1318, 1397, 1568, 1760, 1976};
  int mnote = 0;
  int k     = 0;
  int mgap  = 0;
  bit valid = 0;

  always @(posedge inclock) begin
    if (reset) begin
      mnote = 0; k = 0; mgap = 0; valid = 1;
    end else begin
      if (int'(bus.note_in) != mnote) begin
        mnote = int'(bus.note_in);
        k = 0;
      end else if (mnote >= 1 && mnote <= 21) begin
        k++;
      end
`ifdef MUSIC_NOTE_GAP_EN
      if (bus.beat) mgap = GAP;
      else if (mgap > 0) mgap--;
`endif
    end
  end

  always @(negedge inclock) begin
    if (valid) begin
      int e_spk, e_deg, e_oct, e_play, h;
      e_spk = 0; e_deg = 0; e_oct = 0; e_play = 0;
      if (mnote >= 1 && mnote <= 21) begin
        h      = CLK / (2 * freq_hz[mnote-1]);
        e_spk  = ((k / h) % 2 == 1 && mgap == 0) ? 1 : 0;
        e_deg  = (mnote - 1) % 7 + 1;
        e_oct  = (mnote - 1) / 7 + 1;
        e_play = 1;
      end
      check("model_spk", int'(bus.spk), e_spk);
      check("model_degree", int'(bus.degree), e_deg);
      check("model_octave", int'(bus.octave), e_oct);
      check("model_playing", int'(bus.playing), e_play);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge inclock);
  endtask

  initial begin
    reset = 1'b1;
    bus.note_in = 5'd13;
    bus.beat = 1'b0;
    cyc(3);
    check("rst_spk", int'(bus.spk), 0);
    check("rst_degree", int'(bus.degree), 0);
    check("rst_octave", int'(bus.octave), 0);
    check("rst_playing", int'(bus.playing), 0);

    // Release: the next edge latches 13 as a fresh change.
    reset = 1'b0;
    cyc(1);
    check("la_degree", int'(bus.degree), 6);
    check("la_octave", int'(bus.octave), 2);
    check("la_playing", int'(bus.playing), 1);
    check("la_spk_k0", int'(bus.spk), 0);
    cyc(6817);
    check("la_spk_6817", int'(bus.spk), 0);
    cyc(1);
    check("la_spk_6818", int'(bus.spk), 1);
    cyc(6817);
    check("la_spk_13635", int'(bus.spk), 1);
    cyc(1);
    check("la_spk_13636", int'(bus.spk), 0);

    bus.note_in = 5'd0;
    cyc(50);
    check("rest0_spk", int'(bus.spk), 0);
    check("rest0_octave", int'(bus.octave), 0);
    check("rest0_playing", int'(bus.playing), 0);
    bus.note_in = 5'd25;
    cyc(50);
    check("rest25_spk", int'(bus.spk), 0);
    check("rest25_octave", int'(bus.octave), 0);
    check("rest25_degree", int'(bus.degree), 0);
    check("rest25_playing", int'(bus.playing), 0);

    bus.note_in = 5'd13;
    cyc(1 + 7000);
    check("la2_spk_high", int'(bus.spk), 1);
    bus.note_in = 5'd1;
    cyc(1);
    check("do_spk_cleared", int'(bus.spk), 0);
    check("do_degree", int'(bus.degree), 1);
    check("do_octave", int'(bus.octave), 1);
    cyc(22899);
    check("do_spk_22899", int'(bus.spk), 0);
    cyc(1);
    check("do_spk_22900", int'(bus.spk), 1);
    cyc(22899);
    check("do_spk_45799", int'(bus.spk), 1);
    cyc(1);
    check("do_spk_45800", int'(bus.spk), 0);

    // Beat while the tone is high.
    bus.note_in = 5'd13;
    cyc(1 + 6900);
    bus.beat = 1'b1;
    cyc(1);
    bus.beat = 1'b0;
`ifdef MUSIC_NOTE_GAP_EN
    check("gap_first", int'(bus.spk), 0);
    cyc(99);
    check("gap_last", int'(bus.spk), 0);
    cyc(1);
    check("gap_resume", int'(bus.spk), 1);
`else
    check("nogap_first", int'(bus.spk), 1);
    cyc(99);
    check("nogap_mid", int'(bus.spk), 1);
    cyc(1);
    check("nogap_after", int'(bus.spk), 1);
`endif

    reset = 1'b1;
    cyc(1);
    check("rstpulse_spk", int'(bus.spk), 0);
    check("rstpulse_playing", int'(bus.playing), 0);
    reset = 1'b0;
    cyc(1);
    check("restart_spk_k0", int'(bus.spk), 0);
    check("restart_playing", int'(bus.playing), 1);
    cyc(6817);
    check("restart_spk_6817", int'(bus.spk), 0);
    cyc(1);
    check("restart_spk_6818", int'(bus.spk), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
